audio_level_meter: RTL and testbench
====================================

# audio_level_meter

Parametrised audio level meter for the codec capture path. Accepts signed PCM samples from the I2S deserialiser, computes magnitude, and tracks one of three selectable levels: instantaneous, peak-hold with decay, or windowed mean. Drives a linear thermometer bar graph for the board LEDs and a sticky clip indicator. Sits between the sample loader and the top-level LED outputs.

## Interface
- DATA_WIDTH, 16: sample width, signed two's complement
- NUM_LEDS, 18: bar-graph segments
- WINDOW_LOG2, 10: mean window = 2^WINDOW_LOG2 samples
- HOLD_SAMPLES, 4800: peak-hold duration in samples before decay starts
- DECAY_SHIFT, 4: decay step = peak >> DECAY_SHIFT (minimum 1)
- CLIP_THRESH, 32000: magnitude at or above which clip asserts
- CLIP_HOLD, 24000: samples clip stays asserted after the last clipping sample
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sample  input  DATA_WIDTH  signed sample, already synchronous to clk
- sample_valid  input  1  single-cycle strobe, sample is valid
- mode  input  2  meter_mode_e: 0 INST, 1 PEAK, 2 MEAN, 3 reserved (treated as INST)
- level  output  DATA_WIDTH  unsigned level of selected mode
- level_valid  output  1  one-cycle pulse when level updates
- leds  output  NUM_LEDS  thermometer bar, bit 0 = lowest segment
- clip  output  1  clip indicator

## Operation
- Stage 1 (on sample_valid): mag = sample[MSB] ? (~sample + 1) : sample, unsigned DATA_WIDTH bits; most-negative input yields 2^(DATA_WIDTH-1) with no saturation.
- Stage 2 (one cycle after stage 1 strobe):
  - INST: level <= mag; level_valid pulses.
  - PEAK tracker (runs every sample in all modes): mag > peak → peak <= mag, hold_cnt <= HOLD_SAMPLES; else hold_cnt != 0 → hold_cnt--; else peak != 0 → peak <= peak - max(peak >> DECAY_SHIFT, 1). In PEAK mode level <= updated peak, level_valid pulses every sample.
  - MEAN: acc (DATA_WIDTH+WINDOW_LOG2 bits, no overflow) += mag; cnt (WINDOW_LOG2 bits) increments and wraps. On the sample where cnt wraps to 0: level <= (acc + mag) >> WINDOW_LOG2, acc <= 0, level_valid pulses; no pulse otherwise.
- Mode register: mode sampled every cycle; any change clears acc and cnt and does not itself pulse level_valid; level holds until next update under new mode.
- Clip: mag >= CLIP_THRESH → clip <= 1, clip_cnt <= CLIP_HOLD; else on each valid sample clip_cnt-- while nonzero; clip <= 0 on the sample where clip_cnt reaches 0. Independent of mode.
- Bar: leds[i] = (level >= T(i)), T(i) = floor((i+1)·2^DATA_WIDTH / (NUM_LEDS+1)), elaboration constants; registered.

## Timing
- sample_valid at cycle t → mag registered t+1 → level/level_valid/clip at t+2 → leds at t+3.
- sample_valid back-to-back every cycle supported at full throughput.
- Reset: level, level_valid, leds, clip, peak, hold_cnt, acc, cnt, clip_cnt, mag, stage strobes all 0; asynchronous assert, outputs zero immediately; reset mid-window discards partial mean.
- Simultaneous new peak and hold expiry: new peak wins. Decay never underflows below 0.
- sample_valid ignored while rst_n low.

## Structure
- Package audio_meter_pkg: typedef enum logic [1:0] meter_mode_e {MODE_INST, MODE_PEAK, MODE_MEAN, MODE_RSVD}; function computing T(i).
- Sub-module led_bar_encoder #(DATA_WIDTH, NUM_LEDS): registered thermometer compare of level; separately testable.

## Test plan
- Defaults, INST: sample -32768 → level 32768, leds 18'h001FF; sample 16'h7FFF → level 32767, leds 18'h001FF; sample -1 → level 1, leds 0; verify level at t+2, leds at t+3.
- PEAK, HOLD_SAMPLES=4, DECAY_SHIFT=4: sample -32768 then zeros → level 32768 for 5 samples, then 30720, 28800, 27000; decays to exactly 0, never wraps.
- MEAN, WINDOW_LOG2=2: samples 100, -200, 300, -400 → single level_valid on 4th sample, level 250; mode change mid-window → partial sum discarded, next 4 samples averaged cleanly.
- Clip, CLIP_HOLD=3: sample 32001 then three zeros → clip 1 through the third zero's update, 0 on it; sample 31999 alone → clip stays 0.
- Reset mid-operation: drive rst_n low while peak=32768, clip=1 → all outputs 0 without a clk edge; first sample after release behaves as from power-up.
- Full-rate: sample_valid high 64 consecutive cycles with ramp → 64 level_valid pulses in INST, no dropped updates.

Source files
------------

// File: rtl/audio_meter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : audio_meter_pkg
// Brief    : Shared meter mode encoding and LED bar threshold helper.
// Revision : 1.0
// ============================================================================
package audio_meter_pkg;

    typedef enum logic [1:0] {
        MODE_INST = 2'd0,
        MODE_PEAK = 2'd1,
        MODE_MEAN = 2'd2,
        MODE_RSVD = 2'd3
    } meter_mode_e;

    typedef logic [63:0] u64_t;

    // Segment idx lights at floor((idx+1) * 2^data_width / (num_leds+1)).
    function automatic u64_t led_threshold(input int data_width, input int num_leds, input int idx);
        return (u64_t'(idx + 1) << data_width) / u64_t'(num_leds + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_level_meter_led_bar.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : led_bar_encoder
// Brief    : Registered linear thermometer encoding of a level value.
// Revision : 1.0
// ============================================================================
module led_bar_encoder
    import audio_meter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LEDS   = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] level,
    output logic [NUM_LEDS-1:0]   leds
);

    logic [NUM_LEDS-1:0] w_hit;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_seg
        localparam logic [DATA_WIDTH-1:0] c_thresh =
            DATA_WIDTH'(led_threshold(DATA_WIDTH, NUM_LEDS, i));
        assign w_hit[i] = (level >= c_thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= '0;
        end else begin
            leds <= w_hit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_level_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : audio_level_meter
// Brief    : Instantaneous / peak-hold / windowed-mean level meter with LED bar and clip.
// Revision : 1.0
// ============================================================================
module audio_level_meter
    import audio_meter_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_LEDS     = 18,
    parameter int WINDOW_LOG2  = 10,
    parameter int HOLD_SAMPLES = 4800,
    parameter int DECAY_SHIFT  = 4,
    parameter int CLIP_THRESH  = 32000,
    parameter int CLIP_HOLD    = 24000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] level,
    output logic                  level_valid,
    output logic [NUM_LEDS-1:0]   leds,
    output logic                  clip
);

    localparam int c_acc_w  = DATA_WIDTH + WINDOW_LOG2;
    localparam int c_hold_w = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int c_clip_w = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;
    localparam logic [c_hold_w-1:0]   c_hold_init   = c_hold_w'(HOLD_SAMPLES);
    localparam logic [c_clip_w-1:0]   c_clip_init   = c_clip_w'(CLIP_HOLD);
    localparam logic [DATA_WIDTH-1:0] c_clip_thresh = DATA_WIDTH'(CLIP_THRESH);

    logic [DATA_WIDTH-1:0]  r_mag;
    logic                   r_s1_valid;
    meter_mode_e            r_mode;
    logic [DATA_WIDTH-1:0]  r_peak;
    logic [c_hold_w-1:0]    r_hold_cnt;
    logic [c_acc_w-1:0]     r_acc;
    logic [WINDOW_LOG2-1:0] r_cnt;
    logic [c_clip_w-1:0]    r_clip_cnt;
    logic [DATA_WIDTH-1:0]  r_level;
    logic                   r_level_valid;
    logic                   r_clip;

    logic [DATA_WIDTH-1:0]  w_mag;
    meter_mode_e            w_mode_eff;
    logic                   w_mode_change;
    logic [DATA_WIDTH-1:0]  w_decay;
    logic [DATA_WIDTH-1:0]  w_peak_next;
    logic [c_hold_w-1:0]    w_hold_next;
    logic [c_acc_w-1:0]     w_mean_sum;
    logic                   w_wrap;

    // Most-negative input wraps to 2^(DATA_WIDTH-1), which fits unsigned.
    assign w_mag         = sample[DATA_WIDTH-1] ? (~sample + DATA_WIDTH'(1)) : sample;
    assign w_mode_eff    = (r_mode == MODE_RSVD) ? MODE_INST : r_mode;
    assign w_mode_change = (meter_mode_e'(mode) != r_mode);
    assign w_mean_sum    = r_acc + c_acc_w'(r_mag);
    assign w_wrap        = &r_cnt;

    always_comb begin
        w_peak_next = r_peak;
        w_hold_next = r_hold_cnt;
        w_decay     = r_peak >> DECAY_SHIFT;
        if (w_decay == '0) begin
            w_decay = DATA_WIDTH'(1);
        end
        if (r_mag > r_peak) begin
            w_peak_next = r_mag;
            w_hold_next = c_hold_init;
        end else if (r_hold_cnt != '0) begin
            w_hold_next = r_hold_cnt - c_hold_w'(1);
        end else if (r_peak != '0) begin
            w_peak_next = r_peak - w_decay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag      <= '0;
            r_s1_valid <= 1'b0;
            r_mode     <= MODE_INST;
        end else begin
            r_s1_valid <= sample_valid;
            r_mode     <= meter_mode_e'(mode);
            if (sample_valid) begin
                r_mag <= w_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak        <= '0;
            r_hold_cnt    <= '0;
            r_level       <= '0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= 1'b0;
            if (r_s1_valid) begin
                r_peak     <= w_peak_next;
                r_hold_cnt <= w_hold_next;
                case (w_mode_eff)
                    MODE_PEAK: begin
                        r_level       <= w_peak_next;
                        r_level_valid <= 1'b1;
                    end
                    MODE_MEAN: begin
                        if (w_wrap) begin
                            r_level       <= DATA_WIDTH'(w_mean_sum >> WINDOW_LOG2);
                            r_level_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_level       <= r_mag;
                        r_level_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    // The window restarts whenever the mode register changes value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_mode_change) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_s1_valid) begin
            r_acc <= w_wrap ? '0 : w_mean_sum;
            r_cnt <= r_cnt + WINDOW_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip     <= 1'b0;
            r_clip_cnt <= '0;
        end else if (r_s1_valid) begin
            if (r_mag >= c_clip_thresh) begin
                r_clip     <= 1'b1;
                r_clip_cnt <= c_clip_init;
            end else if (r_clip_cnt > c_clip_w'(1)) begin
                r_clip_cnt <= r_clip_cnt - c_clip_w'(1);
            end else begin
                r_clip_cnt <= '0;
                r_clip     <= 1'b0;
            end
        end
    end

    led_bar_encoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LEDS   (NUM_LEDS)
    ) u_led_bar (
        .clk   (clk),
        .rst_n (rst_n),
        .level (r_level),
        .leds  (leds)
    );

    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign clip        = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_audio_level_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_audio_level_meter
// Brief    : Directed self-checking bench for audio_level_meter.
// Revision : 1.0
// ============================================================================
module tb_audio_level_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample;
    logic        sample_valid;
    logic [1:0]  mode;
    logic [15:0] level;
    logic        level_valid;
    logic [17:0] leds;
    logic        clip;

    int n_assert = 0;
    int n_fail   = 0;

    audio_level_meter #(
        .DATA_WIDTH   (16),
        .NUM_LEDS     (18),
        .WINDOW_LOG2  (2),
        .HOLD_SAMPLES (4),
        .DECAY_SHIFT  (4),
        .CLIP_THRESH  (32000),
        .CLIP_HOLD    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .mode         (mode),
        .level        (level),
        .level_valid  (level_valid),
        .leds         (leds),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Returns at the falling edge after level/level_valid/clip have updated.
    task automatic send(input logic [15:0] s);
        @(negedge clk);
        sample       = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample       = '0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic signed [15:0] ramp(input int k);
        return 16'(k * 1000 - 32000);
    endfunction

    function automatic logic [15:0] absval(input logic signed [15:0] v);
        return (v < 0) ? 16'(-v) : v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int bad;
        int p;
        int guard;
        int pk [8] = '{32768, 32768, 32768, 32768, 32768, 30720, 28800, 27000};

        rst_n        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        mode         = 2'd0;
        #2;
        chk("reset_level", level, 0);
        chk("reset_level_valid", level_valid, 0);
        chk("reset_leds", leds, 0);
        chk("reset_clip", clip, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Instantaneous mode
        send(16'h8000);
        chk("inst_min_level", level, 32768);
        chk("inst_min_valid", level_valid, 1);
        chk("inst_min_clip", clip, 1);
        chk("inst_min_leds_not_yet", leds, 0);
        idle(1);
        chk("inst_min_leds", leds, 18'h001FF);
        chk("inst_valid_single_pulse", level_valid, 0);
        send(16'h7FFF);
        chk("inst_max_level", level, 32767);
        idle(1);
        chk("inst_max_leds", leds, 18'h001FF);
        send(16'hFFFF);
        chk("inst_m1_level", level, 1);
        idle(1);
        chk("inst_m1_leds", leds, 0);

        // Back-to-back samples at full rate
        pulses = 0;
        bad    = 0;
        for (int k = 0; k < 67; k++) begin
            @(negedge clk);
            if (level_valid) begin
                pulses++;
                if (k < 2 || level !== absval(ramp(k - 2))) bad++;
            end
            if (k < 64) begin
                sample       = ramp(k);
                sample_valid = 1'b1;
            end else begin
                sample_valid = 1'b0;
                sample       = '0;
            end
        end
        chk("full_rate_pulses", pulses, 64);
        chk("full_rate_data_errors", bad, 0);

        // Asynchronous reset mid-operation
        send(16'h8000);
        chk("pre_reset_level", level, 32768);
        chk("pre_reset_clip", clip, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_level", level, 0);
        chk("async_reset_valid", level_valid, 0);
        chk("async_reset_leds", leds, 0);
        chk("async_reset_clip", clip, 0);
        @(negedge clk);
        sample       = 16'h7000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample       = '0;
        rst_n        = 1'b1;
        idle(2);
        chk("valid_ignored_in_reset_level", level, 0);
        chk("valid_ignored_in_reset_valid", level_valid, 0);

        // Peak hold, decay and clip stretch
        mode = 2'd1;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 16'h8000 : 16'h0000);
            chk($sformatf("peak_level_%0d", i), level, pk[i]);
            chk($sformatf("peak_valid_%0d", i), level_valid, 1);
            if (i <= 3) chk($sformatf("clip_hold_%0d", i), clip, (i < 3) ? 1 : 0);
        end
        p     = 27000;
        bad   = 0;
        guard = 0;
        while (p != 0 && guard < 400) begin
            p = p - (((p >> 4) > 0) ? (p >> 4) : 1);
            send(16'h0000);
            if (level !== 16'(p)) bad++;
            guard++;
        end
        chk("peak_decay_errors", bad, 0);
        send(16'h0000);
        chk("peak_floor_zero", level, 0);
        chk("peak_floor_valid", level_valid, 1);

        // Clip threshold boundary
        send(16'd31999);
        chk("clip_below_thresh", clip, 0);
        send(16'd32000);
        chk("clip_at_thresh", clip, 1);

        // Windowed mean
        mode = 2'd2;
        idle(2);
        send(16'd100);
        chk("mean_s1_valid", level_valid, 0);
        chk("mean_level_holds", level, 32000);
        send(16'hFF38);
        chk("mean_s2_valid", level_valid, 0);
        send(16'd300);
        chk("mean_s3_valid", level_valid, 0);
        send(16'hFE70);
        chk("mean_s4_valid", level_valid, 1);
        chk("mean_s4_level", level, 250);

        send(16'd1000);
        send(16'd1000);
        mode = 2'd0;
        idle(2);
        mode = 2'd2;
        idle(2);
        send(16'd8);
        chk("mean_restart_s1_valid", level_valid, 0);
        send(16'hFFF4);
        chk("mean_restart_s2_valid", level_valid, 0);
        send(16'd16);
        chk("mean_restart_s3_valid", level_valid, 0);
        chk("mean_restart_level_holds", level, 250);
        send(16'hFFEC);
        chk("mean_restart_s4_valid", level_valid, 1);
        chk("mean_restart_level", level, 14);

        // Reserved mode behaves as instantaneous
        mode = 2'd3;
        idle(2);
        send(16'd777);
        chk("rsvd_level", level, 777);
        chk("rsvd_valid", level_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
